// File: rtl/aig_seq_pkg.sv
// Shared types and step functions for the AIG vector sequencer.
// Step functions work on 32-bit containers masked to the requested width.
package aig_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } seq_state_t;

  localparam logic [15:0] DEFAULT_MISR_POLY = 16'h8016;
  localparam logic [6:0]  DEFAULT_LFSR_TAPS = 7'h60;
  localparam logic [6:0]  DEFAULT_LFSR_SEED = 7'h01;

  function automatic logic [31:0] width_mask(input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return mask[31:0];
  endfunction

  // Shift left, fold the polynomial back in when the MSB leaves, then absorb the response.
  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d,
                                            input logic [31:0] poly, input int unsigned w);
    logic msb;
    msb = |(m & (32'd1 << (w - 1)));
    return ((m << 1) ^ (msb ? poly : 32'd0) ^ d) & width_mask(w);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps,
                                            input int unsigned n);
    return ((s << 1) | {31'd0, ^(s & taps)}) & width_mask(n);
  endfunction

endpackage

// File: rtl/aig_misr.sv
// Parametric multiple-input signature register with synchronous clear and enable.
// Clear has priority over enable so a new run always starts from zero.
module aig_misr
  import aig_seq_pkg::*;
#(
  parameter int unsigned      W    = 16,
  parameter int unsigned      D_W  = 2,
  parameter logic [W-1:0]     POLY = W'(DEFAULT_MISR_POLY)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           enable_i,
  input  logic [D_W-1:0] data_i,
  output logic [W-1:0]   sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] step_val;

  always_comb begin
    step_val = W'(misr_step(32'(sig_q), 32'(data_i), 32'(POLY), W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clear_i) begin
      sig_q <= '0;
    end else if (enable_i) begin
      sig_q <= step_val;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/aig_vector_sequencer.sv
// Drives vectors into a combinational cone, samples its response after a settle window
// and compacts every sample into a MISR signature reported once per run.
module aig_vector_sequencer
  import aig_seq_pkg::*;
#(
  parameter int unsigned         N_IN      = 7,
  parameter int unsigned         N_OUT     = 2,
  parameter int unsigned         SETTLE    = 0,
  parameter int unsigned         MISR_W    = 16,
  parameter logic [MISR_W-1:0]   MISR_POLY = MISR_W'(DEFAULT_MISR_POLY),
  parameter logic [N_IN-1:0]     LFSR_TAPS = N_IN'(DEFAULT_LFSR_TAPS),
  parameter logic [N_IN-1:0]     LFSR_SEED = N_IN'(DEFAULT_LFSR_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [15:0]       num_vec_i,
  output logic [N_IN-1:0]   x_o,
  input  logic [N_OUT-1:0]  f_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sig_valid_o,
  output logic [MISR_W-1:0] signature_o,
  output logic [15:0]       vec_idx_o
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [N_IN-1:0] SEED_EFF   = (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;
  localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);

  seq_state_t        state_q, state_d;
  logic              mode_q;
  logic [15:0]       num_q;
  logic [N_IN-1:0]   gen_q, gen_next;
  logic [15:0]       idx_q;
  logic [7:0]        wait_cnt_q;
  logic              run_start;
  logic              misr_en;
  logic [MISR_W-1:0] misr_sig;

  always_comb begin
    gen_next = gen_q + N_IN'(1);
    if (mode_q) begin
      gen_next = N_IN'(lfsr_step(32'(gen_q), 32'(LFSR_TAPS), N_IN));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    misr_en   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          run_start = 1'b1;
          state_d   = (num_vec_i == 16'd0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        busy_o  = 1'b1;
        state_d = (SETTLE != 0) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (wait_cnt_q <= 8'd1) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy_o  = 1'b1;
        misr_en = 1'b1;
        state_d = (idx_q + 16'd1 == num_q) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers follow the current state; start is only honoured through run_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      num_q       <= '0;
      gen_q       <= '0;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      x_o         <= '0;
      signature_o <= '0;
      sig_valid_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_start) begin
            mode_q      <= mode_i;
            num_q       <= num_vec_i;
            gen_q       <= mode_i ? SEED_EFF : '0;
            idx_q       <= '0;
            sig_valid_o <= 1'b0;
          end
        end
        ST_APPLY: begin
          x_o        <= gen_q;
          wait_cnt_q <= SETTLE_CNT;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        ST_CAPTURE: begin
          gen_q <= gen_next;
          idx_q <= idx_q + 16'd1;
        end
        ST_DONE: begin
          signature_o <= misr_sig;
          sig_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vec_idx_o = idx_q;

  aig_misr #(
    .W    (MISR_W),
    .D_W  (N_OUT),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (run_start),
    .enable_i (misr_en),
    .data_i   (f_i),
    .sig_o    (misr_sig)
  );

endmodule

// File: tb/tb_aig_vector_sequencer.sv
// Scoreboard bench: expected vectors are queued at start and popped as each vector appears on x_o.
// Two instances cover SETTLE=0 and SETTLE=2.
module tb_aig_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, mode0 = 1'b0;
  logic [15:0] num0 = '0;
  logic [6:0]  x0;
  logic [1:0]  f0;
  logic        busy0, done0, sv0;
  logic [15:0] sig0, idx0;
  logic        tie_en0 = 1'b0;
  logic [1:0]  tie_val0 = 2'b00;

  logic        start2 = 1'b0, mode2 = 1'b0;
  logic [15:0] num2 = '0;
  logic [6:0]  x2;
  logic [1:0]  f2;
  logic        busy2, done2, sv2;
  logic [15:0] sig2, idx2;

  assign f0 = tie_en0 ? tie_val0 : x0[1:0];
  assign f2 = x2[1:0];

  int tests_run = 0;
  int tests_failed = 0;
  logic [6:0] exp_x_q[$];

  aig_vector_sequencer #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .mode_i(mode0), .num_vec_i(num0),
    .x_o(x0), .f_i(f0), .busy_o(busy0), .done_o(done0), .sig_valid_o(sv0),
    .signature_o(sig0), .vec_idx_o(idx0)
  );

  aig_vector_sequencer #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .mode_i(mode2), .num_vec_i(num2),
    .x_o(x2), .f_i(f2), .busy_o(busy2), .done_o(done2), .sig_valid_o(sv2),
    .signature_o(sig2), .vec_idx_o(idx2)
  );

  function automatic logic [15:0] model_misr(input logic [15:0] m, input logic [1:0] f);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h8016 : 16'h0000) ^ {14'd0, f};
  endfunction

  function automatic logic [6:0] model_lfsr(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic build_expected(input logic mode, input int num, input logic tie_en,
                                input logic [1:0] tie, output logic [15:0] sig);
    logic [6:0] v;
    logic [1:0] f;
    exp_x_q.delete();
    v   = mode ? 7'h01 : 7'h00;
    sig = 16'h0000;
    for (int k = 0; k < num; k++) begin
      exp_x_q.push_back(v);
      f   = tie_en ? tie : v[1:0];
      sig = model_misr(sig, f);
      v   = mode ? model_lfsr(v) : v + 7'd1;
    end
  endtask

  // One run on the SETTLE=0 instance; observation n is taken n falling edges after start is driven.
  task automatic run_dut0(input string name, input logic mode, input logic [15:0] num,
                          input logic tie_en, input logic [1:0] tie, output logic [15:0] got_sig);
    logic [15:0] exp_sig;
    logic [6:0]  x_before, exp_x;
    int          done_cyc;
    build_expected(mode, int'(num), tie_en, tie, exp_sig);
    tie_en0  = tie_en;
    tie_val0 = tie;
    @(negedge clk);
    x_before = x0;
    mode0  = mode;
    num0   = num;
    start0 = 1'b1;
    done_cyc = 1 + int'(num) * 2;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c >= 2 && (c % 2) == 0 && c < done_cyc) begin
        tests_run++;
        if (exp_x_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL %s x_o: got %h with no vector expected", name, x0);
        end else begin
          exp_x = exp_x_q.pop_front();
          if (x0 !== exp_x) begin
            tests_failed++;
            $display("[TB] FAIL %s x_o[%0d]: got %h expected %h", name, (c - 2) / 2, x0, exp_x);
          end
        end
        tests_run++;
        if (idx0 !== 16'((c - 2) / 2)) begin
          tests_failed++;
          $display("[TB] FAIL %s vec_idx_o: got %0d expected %0d", name, idx0, (c - 2) / 2);
        end
      end
      if (c < done_cyc) begin
        tests_run++;
        if (busy0 !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s busy_o cycle %0d: got %b expected 1", name, c, busy0);
        end
      end
      if (c <= done_cyc) begin
        tests_run++;
        if (done0 !== (c == done_cyc)) begin
          tests_failed++;
          $display("[TB] FAIL %s done_o cycle %0d: got %b expected %b", name, c, done0, c == done_cyc);
        end
      end
    end
    got_sig = sig0;
    tests_run++;
    if (sv0 !== 1'b1 || sig0 !== exp_sig) begin
      tests_failed++;
      $display("[TB] FAIL %s signature: got %b/%h expected 1/%h", name, sv0, sig0, exp_sig);
    end
    tests_run++;
    if (exp_x_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s vectors: %0d never applied, expected 0", name, exp_x_q.size());
    end
    if (num == 16'd0) begin
      tests_run++;
      if (x0 !== x_before) begin
        tests_failed++;
        $display("[TB] FAIL %s x_o hold: got %h expected %h", name, x0, x_before);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({x0, busy0, done0, sv0, sig0, idx0} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset dut0: got x=%h b=%b d=%b v=%b s=%h i=%h expected all 0",
               x0, busy0, done0, sv0, sig0, idx0);
    end
    tests_run++;
    if ({x2, busy2, done2, sv2, sig2, idx2} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset dut2: got x=%h b=%b d=%b v=%b s=%h i=%h expected all 0",
               x2, busy2, done2, sv2, sig2, idx2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_vectors;
    logic [15:0] s;
    run_dut0("num0", 1'b0, 16'd0, 1'b0, 2'b00, s);
    tests_run++;
    if (s !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL num0 const sig: got %h expected 0000", s);
    end
  endtask

  task automatic test_count;
    logic [15:0] s;
    run_dut0("count4", 1'b0, 16'd4, 1'b1, 2'b00, s);
    tests_run++;
    if (s !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL count4 const sig: got %h expected 0000", s);
    end
  endtask

  task automatic test_misr;
    logic [15:0] s;
    run_dut0("misr3", 1'b0, 16'd3, 1'b1, 2'b01, s);
    tests_run++;
    if (s !== 16'h0007) begin
      tests_failed++;
      $display("[TB] FAIL misr3 const sig: got %h expected 0007", s);
    end
  endtask

  task automatic test_lfsr;
    logic [15:0] s;
    run_dut0("lfsr8", 1'b1, 16'd8, 1'b0, 2'b00, s);
  endtask

  task automatic test_back_to_back;
    logic [15:0] s1, s2;
    run_dut0("b2b_a", 1'b1, 16'd5, 1'b0, 2'b00, s1);
    run_dut0("b2b_b", 1'b0, 16'd6, 1'b0, 2'b00, s2);
  endtask

  // SETTLE=2 run that wraps the counter; start pulses mid-run and in the DONE cycle must be ignored.
  task automatic test_wrap_settle;
    logic [15:0] exp_sig;
    logic [6:0]  exp_x;
    int          done_cyc;
    build_expected(1'b0, 130, 1'b0, 2'b00, exp_sig);
    done_cyc = 521;
    @(negedge clk);
    mode2  = 1'b0;
    num2   = 16'd130;
    start2 = 1'b1;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(negedge clk);
      start2 = (c == 50 || c == 300 || c == done_cyc);
      mode2  = start2;
      num2   = start2 ? 16'd3 : 16'd130;
      if (c >= 2 && ((c - 2) % 4) == 0 && c < done_cyc) begin
        tests_run++;
        if (exp_x_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL wrap x_o: got %h with no vector expected", x2);
        end else begin
          exp_x = exp_x_q.pop_front();
          if (x2 !== exp_x || idx2 !== 16'((c - 2) / 4)) begin
            tests_failed++;
            $display("[TB] FAIL wrap vec %0d: got %h/%0d expected %h/%0d",
                     (c - 2) / 4, x2, idx2, exp_x, (c - 2) / 4);
          end
        end
      end
      if (c <= done_cyc && done2 !== (c == done_cyc)) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wrap done_o cycle %0d: got %b expected %b", c, done2, c == done_cyc);
      end
    end
    start2 = 1'b0;
    tests_run++;
    if (sv2 !== 1'b1 || sig2 !== exp_sig) begin
      tests_failed++;
      $display("[TB] FAIL wrap signature: got %b/%h expected 1/%h", sv2, sig2, exp_sig);
    end
    tests_run++;
    if (busy2 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap start in DONE: busy_o got %b expected 0", busy2);
    end
    tests_run++;
    if (exp_x_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wrap vectors: %0d never applied, expected 0", exp_x_q.size());
    end
  endtask

  task automatic test_reset_midrun;
    logic [15:0] clean_sig, rerun_sig;
    run_dut0("clean8", 1'b0, 16'd8, 1'b0, 2'b00, clean_sig);
    @(negedge clk);
    mode0  = 1'b0;
    num0   = 16'd8;
    start0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    tests_run++;
    if (idx0 !== 16'd4 || x0 !== 7'd4) begin
      tests_failed++;
      $display("[TB] FAIL midrun position: got idx %0d x %h expected 4/04", idx0, x0);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({x0, busy0, done0, sv0, sig0, idx0} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrun reset: got x=%h b=%b d=%b v=%b s=%h i=%h expected all 0",
               x0, busy0, done0, sv0, sig0, idx0);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (done0 !== 1'b0 || sv0 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun hold: got done %b valid %b expected 0/0", done0, sv0);
    end
    rst = 1'b0;
    run_dut0("rerun8", 1'b0, 16'd8, 1'b0, 2'b00, rerun_sig);
    tests_run++;
    if (rerun_sig !== clean_sig) begin
      tests_failed++;
      $display("[TB] FAIL rerun signature: got %h expected %h", rerun_sig, clean_sig);
    end
  endtask

  initial begin
    test_reset();
    test_zero_vectors();
    test_count();
    test_misr();
    test_lfsr();
    test_back_to_back();
    test_wrap_settle();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
